branch_pred_ctrl: RTL and testbench
===================================

BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, width of the predictor index (table depth 2**IDX_W).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  in  1  pipeline stall; freezes all state.
REQ-005 SHALL have port if_pc  in  32  fetch-stage PC; predictor lookup index is if_pc[IDX_W+1:2].
REQ-006 SHALL have port if_pred_taken  out  1  predicted direction for if_pc.
REQ-007 SHALL have port ex_valid  in  1  execute-stage instruction valid.
REQ-008 SHALL have port ex_is_branch  in  1  execute-stage instruction is a conditional branch (beq/bne/blez/bgtz/bltz/bgez).
REQ-009 SHALL have port ex_pc  in  32  PC of the resolving branch.
REQ-010 SHALL have port ex_pred_taken  in  1  prediction carried with that branch.
REQ-011 SHALL have port ex_take_branch  in  1  resolved direction from the branch comparator.
REQ-012 SHALL have port ex_target  in  32  resolved branch target.
REQ-013 SHALL have port redirect_valid  out  1  fetch must load redirect_pc.
REQ-014 SHALL have port redirect_pc  out  32  corrected fetch address.
REQ-015 SHALL have port flush_if  out  1  kill the fetch-stage instruction.
REQ-016 SHALL have port flush_id  out  1  kill the decode-stage instruction.
REQ-017 SHALL have port br_count  out  16  resolved-branch counter.
REQ-018 SHALL have port mis_count  out  16  mispredict counter.

Function
REQ-019 SHALL hold 2**IDX_W 2-bit saturating counters; if_pred_taken = counter[if_pc index][1], combinational.
REQ-020 SHALL define a resolve event as ex_valid & ex_is_branch & !stall & state==IDLE.
REQ-021 SHALL, on a resolve event, update counter[ex_pc[IDX_W+1:2]]: +1 if ex_take_branch (saturate at 3), -1 otherwise (saturate at 0).
REQ-022 SHALL return the pre-update counter value when lookup and update hit the same index in one cycle (no bypass).
REQ-023 SHALL increment br_count on every resolve event and mis_count on every resolve event with ex_pred_taken != ex_take_branch; both saturate at 0xFFFF.
REQ-024 SHALL implement FSM states IDLE, REDIRECT, RECOVER.
REQ-025 SHALL transition IDLE->REDIRECT on a mispredicting resolve event; otherwise stay in IDLE.
REQ-026 SHALL, in REDIRECT, assert redirect_valid, flush_if and flush_id for one cycle, then go to RECOVER.
REQ-027 SHALL latch redirect_pc at the resolve event: ex_target if ex_take_branch, else ex_pc+8 (delay slot preserved in both cases); value wraps modulo 2**32.
REQ-028 SHALL, in RECOVER, assert flush_id only, ignore ex_* inputs, then return to IDLE.
REQ-029 SHALL ignore ex_* inputs in REDIRECT and RECOVER (wrong-path instructions): no table update, no counter increment.
REQ-030 SHALL, while stall=1, hold the FSM state, table, counters, redirect_pc and all registered outputs unchanged.
REQ-031 SHALL give a misprediction-to-redirect latency of exactly 1 cycle (redirect_valid high in the cycle after the resolve edge), with a total penalty of 2 unstalled cycles.

Reset
REQ-032 SHALL, on rst_n=0, immediately set all counters to 2'b01 (weakly not-taken), state to IDLE, redirect_valid/flush_if/flush_id to 0, redirect_pc to 0, br_count and mis_count to 0.
REQ-033 SHALL, on reset asserted in REDIRECT or RECOVER, abort the redirect; no redirect_valid is issued after release.
REQ-034 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-035 SHALL take FSM state encodings, the counter reset value (2'b01) and the delay-slot offset (8) from the shared cpu package.
REQ-036 SHALL place the counter table with its saturating update logic in one sub-module, bht_table.

Verification
REQ-037 SHALL cover: reset, then if_pc=0x00400010 -> if_pred_taken=0; br_count=0, mis_count=0.
REQ-038 SHALL cover: resolve ex_pc=0x00400010, pred=0, taken=1, target=0x00400100 -> next cycle redirect_valid=1, redirect_pc=0x00400100, flush_if=flush_id=1; following cycle flush_id=1 only; mis_count=1.
REQ-039 SHALL cover: three taken resolves at index 4 -> counter 3; one not-taken -> counter 2, if_pred_taken still 1.
REQ-040 SHALL cover: pred=1, taken=0 at ex_pc=0xFFFFFFFC -> redirect_pc=0x00000004 (wrap).
REQ-041 SHALL cover: a second mispredicting branch presented during RECOVER -> ignored, br_count unchanged; stall=1 held for 3 cycles in REDIRECT -> redirect_valid held, no state advance.
REQ-042 SHALL cover: rst_n pulsed low during REDIRECT -> all outputs 0 immediately; no redirect after release.

Source files
------------

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared definitions for the branch predictor / redirect controller:
// FSM encodings, counter reset value and delay-slot offset.
package branch_pred_ctrl_pkg;

    localparam int unsigned CTR_W    = 2;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ADDR_W   = 32;

    // Weakly not-taken
    localparam logic [CTR_W-1:0]  CTR_RESET         = 2'b01;
    localparam logic [CTR_W-1:0]  CTR_MAX           = 2'b11;
    localparam logic [CTR_W-1:0]  CTR_MIN           = 2'b00;
    // Fall-through skips the branch and its delay slot
    localparam logic [ADDR_W-1:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        RECOVER  = 2'd2
    } bp_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_bht_table.sv
// Branch history table: 2**IDX_W 2-bit saturating counters with a
// combinational read port and one registered update port.
module bht_table
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken_c,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [CTR_W-1:0] upd_cur_c;
    logic [CTR_W-1:0] upd_nx_c;

    // Read returns the stored value; a same-cycle update is not bypassed
    assign rd_taken_c = ctr_q[rd_idx][CTR_W-1];
    assign upd_cur_c  = ctr_q[upd_idx];

    always_comb begin
        upd_nx_c = upd_cur_c;
        if (upd_taken) begin
            if (upd_cur_c != CTR_MAX) upd_nx_c = upd_cur_c + CTR_W'(1);
        end else begin
            if (upd_cur_c != CTR_MIN) upd_nx_c = upd_cur_c - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= CTR_RESET;
        end else if (upd_en) begin
            ctr_q[upd_idx] <= upd_nx_c;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Direction predictor plus mispredict redirect/flush sequencer with
// resolved-branch and mispredict statistics.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [31:0]       if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [31:0]       ex_pc,
    input  logic              ex_pred_taken,
    input  logic              ex_take_branch,
    input  logic [31:0]       ex_target,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mis_count
);

    bp_state_e        state_q;
    bp_state_e        state_nx;
    logic             resolve_c;
    logic             mispredict_c;
    logic             redirect_valid_nx;
    logic             flush_if_nx;
    logic             flush_id_nx;
    logic [IDX_W-1:0] if_idx_c;
    logic [IDX_W-1:0] ex_idx_c;
    logic             unused_pc_bits;

    assign if_idx_c       = if_pc[IDX_W+1:2];
    assign ex_idx_c       = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Wrong-path ex_* inputs are ignored outside IDLE
    assign resolve_c    = ex_valid & ex_is_branch & ~stall & (state_q == IDLE);
    assign mispredict_c = resolve_c & (ex_pred_taken != ex_take_branch);

    bht_table #(
        .IDX_W      (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (if_idx_c),
        .rd_taken_c (if_pred_taken),
        .upd_en     (resolve_c),
        .upd_idx    (ex_idx_c),
        .upd_taken  (ex_take_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // Next state, and registered outputs decoded from it
    always_comb begin
        state_nx          = state_q;
        redirect_valid_nx = 1'b0;
        flush_if_nx       = 1'b0;
        flush_id_nx       = 1'b0;
        if (!stall) begin
            unique case (state_q)
                IDLE:     if (mispredict_c) state_nx = REDIRECT;
                REDIRECT: state_nx = RECOVER;
                RECOVER:  state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
        if (state_nx == REDIRECT) begin
            redirect_valid_nx = 1'b1;
            flush_if_nx       = 1'b1;
        end
        if (state_nx != IDLE) flush_id_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
        end else begin
            redirect_valid <= redirect_valid_nx;
            flush_if       <= flush_if_nx;
            flush_id       <= flush_id_nx;
        end
    end

    // Corrected fetch address captured at the mispredicting resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= '0;
        end else if (mispredict_c) begin
            redirect_pc <= ex_take_branch ? ex_target : ex_pc + DELAY_SLOT_OFFSET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (resolve_c)    br_count  <= sat_inc(br_count);
            if (mispredict_c) mis_count <= sat_inc(mis_count);
        end
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed vector table, reset
// abort sequence, and randomized traffic against a behavioural model.
module tb_branch_pred_ctrl;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_take_branch;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl #(.IDX_W(IDX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_take_branch (ex_take_branch),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .br_count       (br_count),
        .mis_count      (mis_count)
    );

    typedef struct {
        logic        st, v, b, pt, tk;
        logic [31:0] pc, tgt, ipc;
        logic        e_pred, e_rv, e_fi, e_fd;
        logic [31:0] e_rpc;
        int          e_br, e_mis;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: counter array, remaining penalty cycles, statistics
    int          m_ctr [DEPTH];
    int          m_pen;
    logic [31:0] m_rpc;
    int          m_br, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_ctr[i] = 1;
        m_pen = 0;
        m_rpc = 32'h0;
        m_br  = 0;
        m_mis = 0;
    endtask

    // Effect of one rising edge with the given inputs
    task automatic m_edge(input logic st, v, b, input logic [31:0] pc,
                          input logic pt, tk, input logic [31:0] tgt);
        int i;
        if (st) return;
        if (m_pen > 0) begin
            m_pen--;
        end else if (v && b) begin
            i = idx_of(pc);
            m_br = (m_br < 65535) ? m_br + 1 : 65535;
            m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (pt != tk) begin
                m_mis = (m_mis < 65535) ? m_mis + 1 : 65535;
                m_pen = 2;
                m_rpc = tk ? tgt : pc + 32'd8;
            end
        end
    endtask

    task automatic drive(input logic st, v, b, input logic [31:0] pc,
                         input logic pt, tk, input logic [31:0] tgt, ipc);
        stall          = st;
        ex_valid       = v;
        ex_is_branch   = b;
        ex_pc          = pc;
        ex_pred_taken  = pt;
        ex_take_branch = tk;
        ex_target      = tgt;
        if_pc          = ipc;
    endtask

    function automatic vec_t mk(input logic st, v, b, input logic [31:0] pc,
                                input logic pt, tk, input logic [31:0] tgt, ipc,
                                input logic ep, erv, efi, efd, input logic [31:0] erpc,
                                input int ebr, emis);
        vec_t t;
        t.st = st; t.v = v; t.b = b; t.pc = pc; t.pt = pt; t.tk = tk;
        t.tgt = tgt; t.ipc = ipc; t.e_pred = ep; t.e_rv = erv; t.e_fi = efi;
        t.e_fd = efd; t.e_rpc = erpc; t.e_br = ebr; t.e_mis = emis;
        return t;
    endfunction

    localparam logic [31:0] PC4  = 32'h0040_0010;
    localparam logic [31:0] PC8  = 32'h0040_0020;
    localparam logic [31:0] PCW  = 32'hFFFF_FFFC;

    initial begin
        logic        st, v, b, pt, tk;
        logic [31:0] pc, tgt, ipc;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, PC4);
        rst_n = 1'b0;
        #12;
        chk("reset_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("reset_flush", {30'h0, flush_if, flush_id}, 32'h0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_counts", {br_count, mis_count}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        //     st v  b  pc    pt tk tgt            ipc   pred rv fi fd rpc            br mis
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 0, 0, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 1, 1, PC4,   0, 1, 32'h0040_0100, PC4, 0, 1, 1, 1, 32'h0040_0100, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 1, 0, 0, 1, 32'h0,         1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 1, 0, 0, 0, 32'h0,         1, 1));
        vecs.push_back(mk(0, 1, 1, PC4,   1, 1, 32'h0040_0200, PC4, 1, 0, 0, 0, 32'h0,         2, 1));
        vecs.push_back(mk(0, 1, 1, PC4,   1, 1, 32'h0040_0200, PC4, 1, 0, 0, 0, 32'h0,         3, 1));
        vecs.push_back(mk(0, 1, 1, PC4,   1, 1, 32'h0040_0200, PC4, 1, 0, 0, 0, 32'h0,         4, 1));
        vecs.push_back(mk(0, 1, 1, PC4,   0, 0, 32'h0040_0200, PC4, 1, 0, 0, 0, 32'h0,         5, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 1, 0, 0, 0, 32'h0,         5, 1));
        vecs.push_back(mk(0, 1, 1, PCW,   1, 0, 32'h1234_5678, PCW, 0, 1, 1, 1, 32'h0000_0004, 6, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PCW, 0, 0, 0, 1, 32'h0,         6, 2));
        vecs.push_back(mk(0, 1, 1, PC4,   0, 1, 32'h0000_0000, PC4, 1, 0, 0, 0, 32'h0,         6, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 1, 0, 0, 0, 32'h0,         6, 2));
        vecs.push_back(mk(0, 1, 1, PC8,   1, 0, 32'h0000_0000, PC8, 0, 1, 1, 1, 32'h0040_0028, 7, 3));
        vecs.push_back(mk(1, 1, 1, PC4,   0, 1, 32'h0000_0000, PC8, 0, 1, 1, 1, 32'h0040_0028, 7, 3));
        vecs.push_back(mk(1, 1, 1, PC4,   0, 1, 32'h0000_0000, PC8, 0, 1, 1, 1, 32'h0040_0028, 7, 3));
        vecs.push_back(mk(1, 1, 1, PC4,   0, 1, 32'h0000_0000, PC8, 0, 1, 1, 1, 32'h0040_0028, 7, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC8, 0, 0, 0, 1, 32'h0,         7, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC4, 1, 0, 0, 0, 32'h0,         7, 3));
        vecs.push_back(mk(0, 1, 1, PC8,   0, 0, 32'h0,         PC8, 0, 0, 0, 0, 32'h0,         8, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         PC8, 0, 0, 0, 0, 32'h0,         8, 3));

        foreach (vecs[n]) begin
            vec_t t;
            t = vecs[n];
            drive(t.st, t.v, t.b, t.pc, t.pt, t.tk, t.tgt, t.ipc);
            #1;
            chk($sformatf("vec%0d_pred", n), 32'(if_pred_taken), 32'(t.e_pred));
            @(posedge clk) #1;
            chk($sformatf("vec%0d_redirect_valid", n), 32'(redirect_valid), 32'(t.e_rv));
            chk($sformatf("vec%0d_flush_if", n), 32'(flush_if), 32'(t.e_fi));
            chk($sformatf("vec%0d_flush_id", n), 32'(flush_id), 32'(t.e_fd));
            chk($sformatf("vec%0d_br_count", n), 32'(br_count), 32'(t.e_br));
            chk($sformatf("vec%0d_mis_count", n), 32'(mis_count), 32'(t.e_mis));
            if (t.e_rv) chk($sformatf("vec%0d_redirect_pc", n), redirect_pc, t.e_rpc);
        end

        // Reset pulsed while a redirect is pending aborts it
        drive(1'b0, 1'b1, 1'b1, PC4, 1'b0, 1'b1, 32'h0040_0200, PC4);
        @(posedge clk) #1;
        chk("abort_pre_redirect_valid", 32'(redirect_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, PC4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("abort_flush", {30'h0, flush_if, flush_id}, 32'h0);
        chk("abort_redirect_pc", redirect_pc, 32'h0);
        chk("abort_counts", {br_count, mis_count}, 32'h0);
        chk("abort_pred", 32'(if_pred_taken), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            chk("abort_after_release", {29'h0, redirect_valid, flush_if, flush_id}, 32'h0);
        end

        // Randomized traffic against the model
        m_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst_n = 1'b0;
                m_reset();
                #2 rst_n = 1'b1;
            end
            st  = ($urandom_range(0, 5) == 0);
            v   = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 2) != 0);
            pc  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0040_0000) | ($urandom & 32'hFC);
            tk  = 1'($urandom_range(0, 1));
            pt  = ($urandom_range(0, 3) != 0) ? (m_ctr[idx_of(pc)] >= 2) : 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            ipc = 32'h0040_0000 | ($urandom & 32'hFC);
            drive(st, v, b, pc, pt, tk, tgt, ipc);
            #1;
            chk("rnd_pred", 32'(if_pred_taken), 32'(m_ctr[idx_of(ipc)] >= 2));
            m_edge(st, v, b, pc, pt, tk, tgt);
            @(posedge clk) #1;
            chk("rnd_redirect_valid", 32'(redirect_valid), 32'(m_pen == 2));
            chk("rnd_flush_if", 32'(flush_if), 32'(m_pen == 2));
            chk("rnd_flush_id", 32'(flush_id), 32'(m_pen > 0));
            chk("rnd_br_count", 32'(br_count), 32'(m_br));
            chk("rnd_mis_count", 32'(mis_count), 32'(m_mis));
            if (m_pen == 2) chk("rnd_redirect_pc", redirect_pc, m_rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
